// File: rtl/regfile_pkg.sv
// Shared register-file write types and widths.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the scan at rr_ptr, pointer moves past the winner.
module rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan requesters from rr_ptr upward with wraparound; first valid one wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IDX_W'((32'(rr_ptr) + k) % N);
      if (en && !found && req[cand]) begin
        found      = 1'b1;
        gnt[cand]  = 1'b1;
        gnt_idx    = cand;
      end
    end
  end

  // Pointer advances to the source just after the winner on every grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (found) begin
      rr_ptr <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among several writeback sources.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 3,
  parameter bit          ZERO_REG_RO = 1'b1,
  parameter int unsigned CNT_W       = 16,
  localparam int unsigned IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          hold,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*REG_DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          write_enable,
  output logic [REG_ADDR_W-1:0]         write_reg_addr,
  output logic [REG_DATA_W-1:0]         write_data,
  output logic [IDX_W-1:0]              grant_id,
  output logic [CNT_W-1:0]              contention_cnt
);

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               xfer;
  logic               contended;
  rf_wr_t             sel;

  // Grants are suppressed during reset and hold.
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .en      (!hold && !reset),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign contended = ($countones(req_valid) >= 2);

  // Select the granted source's address and data.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel.addr = req_addr[i*REG_ADDR_W +: REG_ADDR_W];
        sel.data = req_data[i*REG_DATA_W +: REG_DATA_W];
      end
    end
  end

  // Register the accepted write; register 0 writes complete but never reach the file.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_enable   <= 1'b0;
      write_reg_addr <= '0;
      write_data     <= '0;
      grant_id       <= '0;
    end else if (xfer) begin
      write_enable   <= !(ZERO_REG_RO && (sel.addr == '0));
      write_reg_addr <= sel.addr;
      write_data     <= sel.data;
      grant_id       <= gnt_idx;
    end else begin
      write_enable   <= 1'b0;
    end
  end

  // Saturating count of cycles with two or more requesters pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      contention_cnt <= '0;
    end else if (contended && !(&contention_cnt)) begin
      contention_cnt <= contention_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed scenarios then random traffic against a behavioural model.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;

  logic [2:0]  req_ready,  req_ready2;
  logic        write_enable, write_enable2;
  logic [4:0]  write_reg_addr, write_reg_addr2;
  logic [31:0] write_data, write_data2;
  logic [1:0]  grant_id, grant_id2;
  logic [15:0] contention_cnt;
  logic [1:0]  contention_cnt2;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_ptr;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_gid;
  int          m_cnt;
  int          m_cnt2;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_REQ(3), .ZERO_REG_RO(1'b1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .write_enable(write_enable), .write_reg_addr(write_reg_addr),
    .write_data(write_data), .grant_id(grant_id), .contention_cnt(contention_cnt)
  );

  regfile_wb_arbiter #(.NUM_REQ(3), .ZERO_REG_RO(1'b1), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .hold(hold),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready2), .write_enable(write_enable2), .write_reg_addr(write_reg_addr2),
    .write_data(write_data2), .grant_id(grant_id2), .contention_cnt(contention_cnt2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid[i]       = v;
    req_addr[5*i +: 5] = a;
    req_data[32*i +: 32] = d;
  endtask

  // One clock: check ready before the edge, advance the model, check registered outputs after.
  task automatic step(output int win);
    logic [2:0] exp_rdy;
    int pop;
    #1;
    win = -1;
    if (!reset && !hold) begin
      for (int k = 0; k < 3; k++) begin
        int c;
        c = (m_ptr + k) % 3;
        if (win < 0 && req_valid[c]) win = c;
      end
    end
    exp_rdy = 3'b000;
    if (win >= 0) exp_rdy[win] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("req_ready_sat", 64'(req_ready2), 64'(exp_rdy));
    pop = $countones(req_valid);
    @(posedge clk);
    if (reset) begin
      m_ptr = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_gid = 0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      if (pop >= 2) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (win >= 0) begin
        m_addr = req_addr[5*win +: 5];
        m_data = req_data[32*win +: 32];
        m_gid  = win;
        m_we   = (m_addr != 5'd0);
        m_ptr  = (win + 1) % 3;
      end else begin
        m_we = 1'b0;
      end
    end
    #1;
    check("write_enable", 64'(write_enable), 64'(m_we));
    check("write_reg_addr", 64'(write_reg_addr), 64'(m_addr));
    check("write_data", 64'(write_data), 64'(m_data));
    check("grant_id", 64'(grant_id), 64'(m_gid));
    check("contention_cnt", 64'(contention_cnt), 64'(m_cnt));
    check("contention_sat", 64'(contention_cnt2), 64'(m_cnt2));
  endtask

  initial begin
    int win;
    int left [3];
    m_ptr = 0; m_we = 0; m_addr = 0; m_data = 0; m_gid = 0; m_cnt = 0; m_cnt2 = 0;
    reset = 1'b1; hold = 1'b0;
    req_valid = '0; req_addr = '0; req_data = '0;

    // Reset with all sources requesting
    for (int i = 0; i < 3; i++) set_src(i, 1'b1, 5'(i + 3), 32'h1000 + 32'(i));
    @(negedge clk);
    step(win);
    step(win);
    check("rst_we", 64'(write_enable), 64'd0);
    check("rst_cnt", 64'(contention_cnt), 64'd0);

    // All three valid, each served twice in order 0,1,2,0,1,2
    reset = 1'b0;
    for (int i = 0; i < 3; i++) left[i] = 2;
    for (int n = 0; n < 6; n++) begin
      step(win);
      check("rr_order", 64'(win), 64'(n % 3));
      check("rr_we", 64'(write_enable), 64'd1);
      if (win >= 0) begin
        left[win]--;
        if (left[win] == 0) set_src(win, 1'b0, 5'd0, 32'd0);
        else set_src(win, 1'b1, 5'(win + 10), $urandom);
      end
    end
    check("sat_cnt", 64'(contention_cnt2), 64'd3);

    // Lone source 1 granted immediately
    set_src(1, 1'b1, 5'd2, 32'h12345678);
    step(win);
    set_src(1, 1'b0, 5'd0, 32'd0);
    check("t2_we", 64'(write_enable), 64'd1);
    check("t2_addr", 64'(write_reg_addr), 64'd2);
    check("t2_data", 64'(write_data), 64'h12345678);
    check("t2_gid", 64'(grant_id), 64'd1);

    // Write to register 0 completes but is suppressed
    set_src(2, 1'b1, 5'd0, 32'hABCDEFFA);
    step(win);
    set_src(2, 1'b0, 5'd0, 32'd0);
    check("t4_we", 64'(write_enable), 64'd0);

    // Hold for three cycles with two sources pending, then release
    hold = 1'b1;
    set_src(0, 1'b1, 5'd7, 32'hA0A0A0A0);
    set_src(1, 1'b1, 5'd8, 32'hB1B1B1B1);
    for (int n = 0; n < 3; n++) step(win);
    hold = 1'b0;
    step(win);
    check("t5_win", 64'(win), 64'd0);
    set_src(0, 1'b0, 5'd0, 32'd0);

    // Reset right after a grant clears the pointer
    step(win);
    set_src(1, 1'b0, 5'd0, 32'd0);
    reset = 1'b1;
    step(win);
    check("t6_we", 64'(write_enable), 64'd0);
    reset = 1'b0;
    set_src(0, 1'b1, 5'd9, 32'h0F0F0F0F);
    set_src(2, 1'b1, 5'd11, 32'hF0F0F0F0);
    step(win);
    check("t6_ptr0", 64'(win), 64'd0);

    // Random traffic obeying the valid/ready protocol
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 2) != 0))
          set_src(i, 1'b1, 5'($urandom_range(0, 31)), $urandom);
      end
      hold  = ($urandom_range(0, 4) == 0);
      reset = ($urandom_range(0, 49) == 0);
      step(win);
      if (win >= 0) set_src(win, 1'b0, 5'd0, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
